// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   uart_state_t      : transmitter FSM states
//   DEFAULT_BAUD_DIV  : clocks per bit for 115200 baud at 50 MHz
//   MAX_DATA_BITS     : widest supported data word
//   parity_of()       : parity of a zero-extended data word
package uart_pkg;

  localparam int unsigned DEFAULT_BAUD_DIV = 434;
  localparam int unsigned MAX_DATA_BITS    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Even parity of the word, inverted for odd parity. Unused upper bits
  // must be zero so they do not disturb the result.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data,
                                     input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO without fall-through.
//   clk, rst      : clock, synchronous active-high reset (flushes contents)
//   push, wdata   : write request and data; ignored when full
//   pop, rdata    : read request and head-of-queue data; ignored when empty
//   full, empty   : occupancy flags
//   level         : number of stored entries
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit: equal addresses with differing MSBs means full.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = LW'(wr_ptr - rd_ptr);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with input FIFO and configurable frame format.
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : word to transmit (DATA_BITS wide)
//   in_valid    : in_data valid; accepted when in_ready is high
//   in_ready    : FIFO not full (forced low while rst is high)
//   txd         : registered serial output, idles high
//   busy        : a frame is in progress
//   frame_done  : high during the last cycle of the final stop bit
//   fifo_level  : current FIFO occupancy
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            txd,
  output logic                            busy,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned BW      = $clog2(BAUD_DIV);
  localparam int unsigned BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned CW      = $clog2(BIT_MAX + 1);

  uart_state_t          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 baud_end;
  logic                 load_par;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;

  assign in_ready  = !fifo_full && !rst;
  assign fifo_push = in_valid && in_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign baud_end   = (baud_q == BW'(BAUD_DIV - 1));
  assign load_par   = parity_of(MAX_DATA_BITS'(fifo_rdata), PARITY_ODD != 0);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_STOP) && baud_end && (bit_q == CW'(STOP_BITS - 1));
  assign txd        = txd_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = '0;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    txd_d    = 1'b1;

    if (state_q != ST_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          par_d    = load_par;
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == CW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (bit_q == CW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_rdata;
              par_d    = load_par;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the upcoming state so the line changes on the
    // same edge as the state, keeping the one-cycle accept-to-start latency.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: four frame formats (8N1, 8E1, 8O1,
// 7N2) at BAUD_DIV=4, a per-cycle expected-waveform scoreboard, table-driven
// single-frame vectors, FIFO-full back-to-back traffic and reset mid-frame.
module tb_uart_tx_cfg;

  localparam int B = 4;

  typedef struct {
    logic txd;
    logic fd;
  } cyc_t;

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         len;
    logic       par;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      din = '0;
  logic [6:0]      din7 = '0;
  logic [3:0]      vld = '0;
  logic [3:0]      txd_v;
  logic [3:0]      busy_v;
  logic [3:0]      fd_v;
  logic [3:0]      rdy_v;
  logic [3:0][2:0] lvl;

  int   cfg_db [4] = '{8, 8, 8, 7};
  int   cfg_pe [4] = '{0, 1, 1, 0};
  int   cfg_po [4] = '{0, 0, 1, 0};
  int   cfg_sb [4] = '{1, 1, 1, 2};

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   sel   = 0;
  logic mon_en = 1'b0;
  cyc_t exp_q [$];
  vec_t vecs [7];
  vec_t v;

  always #5 clk = ~clk;

  uart_tx_cfg #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[0]), .in_ready(rdy_v[0]),
    .txd(txd_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]), .fifo_level(lvl[0]));

  uart_tx_cfg #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[1]), .in_ready(rdy_v[1]),
    .txd(txd_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]), .fifo_level(lvl[1]));

  uart_tx_cfg #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[2]), .in_ready(rdy_v[2]),
    .txd(txd_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]), .fifo_level(lvl[2]));

  uart_tx_cfg #(.BAUD_DIV(B), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .rst(rst), .in_data(din7), .in_valid(vld[3]), .in_ready(rdy_v[3]),
    .txd(txd_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3]), .fifo_level(lvl[3]));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Builds the expected per-cycle txd/frame_done waveform for one word.
  task automatic expect_frame(input int s, input logic [7:0] d);
    logic bits [$];
    logic p;
    cyc_t e;
    bits.push_back(1'b0);
    p = (cfg_po[s] != 0);
    for (int i = 0; i < cfg_db[s]; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (cfg_pe[s] != 0) bits.push_back(p);
    for (int i = 0; i < cfg_sb[s]; i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      for (int j = 0; j < B; j++) begin
        e.txd = bits[i];
        e.fd  = (i == bits.size() - 1) && (j == B - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    cyc_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy_v[sel]) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: got busy with no frame expected (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_txd", int'(txd_v[sel]), int'(e.txd));
            chk("sb_frame_done", int'(fd_v[sel]), int'(e.fd));
          end
        end else begin
          chk("idle_txd", int'(txd_v[sel]), 1);
          chk("idle_frame_done", int'(fd_v[sel]), 0);
        end
      end
    end
  endtask

  task automatic push_word(input int s, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    din     = d;
    din7    = d[6:0];
    vld[s]  = 1'b1;
    while (!rdy_v[s] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept_in_time", int'(n < 1000), 1);
    @(posedge clk);
    #1;
    vld[s] = 1'b0;
    expect_frame(s, d);
  endtask

  task automatic run_vec(input vec_t tv);
    int s, len, fdn, par_at;
    s   = tv.sel;
    sel = s;
    push_word(s, tv.data);
    @(negedge clk);
    chk("lat_busy_low", int'(busy_v[s]), 0);
    chk("lat_txd_high", int'(txd_v[s]), 1);
    chk("lat_level_one", int'(lvl[s]), 1);
    @(negedge clk);
    chk("start_busy", int'(busy_v[s]), 1);
    chk("start_txd_low", int'(txd_v[s]), 0);
    chk("pop_level_zero", int'(lvl[s]), 0);
    par_at = (1 + cfg_db[s]) * B + 1;
    len = 0;
    fdn = 0;
    while (busy_v[s] && len < 2000) begin
      if (fd_v[s]) fdn++;
      if (cfg_pe[s] != 0 && len == par_at) chk("parity_bit", int'(txd_v[s]), int'(tv.par));
      len++;
      @(negedge clk);
    end
    chk("frame_len", len, tv.len);
    chk("frame_done_pulses", fdn, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int   n, fdn, t0;
    logic prev_fd;

    fork
      monitor();
      forever begin
        @(posedge clk);
        cyc++;
      end
    join_none

    vecs[0] = '{0, 8'h55, 40, 1'b0};
    vecs[1] = '{1, 8'h07, 44, 1'b1};
    vecs[2] = '{2, 8'h07, 44, 1'b0};
    vecs[3] = '{2, 8'h00, 44, 1'b1};
    vecs[4] = '{3, 8'h7F, 40, 1'b0};
    vecs[5] = '{0, 8'hA3, 40, 1'b0};
    vecs[6] = '{1, 8'hFF, 44, 1'b0};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) chk("rst_in_ready_low", int'(rdy_v[s]), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk("rst_txd", int'(txd_v[s]), 1);
      chk("rst_busy", int'(busy_v[s]), 0);
      chk("rst_frame_done", int'(fd_v[s]), 0);
      chk("rst_level", int'(lvl[s]), 0);
      chk("rst_in_ready", int'(rdy_v[s]), 1);
    end
    mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // FIFO full: six back-to-back words on 8N1.
    sel = 0;
    push_word(0, 8'h11);
    t0 = cyc;
    push_word(0, 8'h22);
    push_word(0, 8'h33);
    push_word(0, 8'h44);
    push_word(0, 8'h55);
    @(negedge clk);
    chk("full_level", int'(lvl[0]), 4);
    chk("full_in_ready", int'(rdy_v[0]), 0);
    din     = 8'h66;
    vld[0]  = 1'b1;
    prev_fd = 1'b0;
    n = 0;
    while (!rdy_v[0] && n < 500) begin
      prev_fd = fd_v[0];
      @(negedge clk);
      n++;
    end
    chk("full_wait_bounded", int'(n < 500), 1);
    chk("ready_after_final_stop", int'(prev_fd), 1);
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    expect_frame(0, 8'h66);
    fdn = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (fd_v[0]) fdn++;
    end while (busy_v[0] && n < 2000);
    chk("burst_len", cyc - t0 - 1, 240);
    chk("burst_frame_done_rest", fdn, 5);
    chk("burst_sb_drained", exp_q.size(), 0);

    // Reset during data bit 3 with a second word still queued.
    sel = 0;
    push_word(0, 8'hF0);
    push_word(0, 8'h0F);
    repeat (18) @(negedge clk);
    chk("pre_rst_busy", int'(busy_v[0]), 1);
    chk("pre_rst_level", int'(lvl[0]), 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_forces_ready_low", int'(rdy_v[0]), 0);
    @(negedge clk);
    chk("midrst_txd", int'(txd_v[0]), 1);
    chk("midrst_level", int'(lvl[0]), 0);
    chk("midrst_busy", int'(busy_v[0]), 0);
    chk("midrst_frame_done", int'(fd_v[0]), 0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("post_rst_ready", int'(rdy_v[0]), 1);
    mon_en = 1'b1;
    v = '{0, 8'h3C, 40, 1'b0};
    run_vec(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
